// File: rtl/euler_pkg.sv
// Shared definitions for the Euler integrator blocks: sequencer state encoding and default widths.
package euler_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_UPDATE = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_t;

endpackage

// File: rtl/euler_step_counter.sv
// Step index register with synchronous clear-on-load, increment and a look-ahead terminal compare.
module euler_step_counter
    import euler_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             load,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] step_idx,
    output logic             last
);

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            step_idx <= '0;
        end else if (load) begin
            step_idx <= '0;
        end else if (inc) begin
            step_idx <= step_idx + CNT_W'(1);
        end
    end

    // High when the pending increment lands on the terminal count.
    assign last = ((step_idx + CNT_W'(1)) == term);

endmodule

// File: rtl/euler_step_sequencer.sv
// Responder side of the Euler start/done handshake: runs num_steps datapath steps, advancing t_cur by h.
//
// state  | meaning
// IDLE   | wait for start; latch num_steps, t0, h
// REQ    | step_req high, wait for step_ack
// UPDATE | t_cur += h, step_idx += 1, pick REQ or DONE
// DONE   | final_done pulse, back to IDLE
module euler_step_sequencer
    import euler_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_async,
    input  logic             start,
    input  logic [CNT_W-1:0] num_steps,
    input  logic [WIDTH-1:0] t0,
    input  logic [WIDTH-1:0] h,
    output logic             step_req,
    input  logic             step_ack,
    output logic [WIDTH-1:0] t_cur,
    output logic [CNT_W-1:0] step_idx,
    output logic             busy,
    output logic             final_done
);

    seq_state_t       state;
    logic [CNT_W-1:0] num_lat;
    logic [WIDTH-1:0] h_lat;
    logic             cnt_load;
    logic             cnt_inc;
    logic             cnt_last;

    assign cnt_load = (state == ST_IDLE) && start;
    assign cnt_inc  = (state == ST_UPDATE);

    euler_step_counter #(
        .CNT_W (CNT_W)
    ) u_step_counter (
        .clk       (clk),
        .rst_async (rst_async),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .term      (num_lat),
        .step_idx  (step_idx),
        .last      (cnt_last)
    );

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state      <= ST_IDLE;
            step_req   <= 1'b0;
            busy       <= 1'b0;
            final_done <= 1'b0;
            t_cur      <= '0;
            num_lat    <= '0;
            h_lat      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        num_lat <= num_steps;
                        h_lat   <= h;
                        t_cur   <= t0;
                        busy    <= 1'b1;
                        if (num_steps == '0) begin
                            state      <= ST_DONE;
                            final_done <= 1'b1;
                        end else begin
                            state    <= ST_REQ;
                            step_req <= 1'b1;
                        end
                    end
                end
                ST_REQ: begin
                    if (step_ack) begin
                        state    <= ST_UPDATE;
                        step_req <= 1'b0;
                    end
                end
                ST_UPDATE: begin
                    // Wraps modulo 2^WIDTH by construction.
                    t_cur <= t_cur + h_lat;
                    if (cnt_last) begin
                        state      <= ST_DONE;
                        final_done <= 1'b1;
                    end else begin
                        state    <= ST_REQ;
                        step_req <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state      <= ST_IDLE;
                    final_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state      <= ST_IDLE;
                    step_req   <= 1'b0;
                    final_done <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
